// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate sequencer: state encoding and
// elaboration-time parameter legality helpers.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam int MAX_REQ = 16;

    // Number of bits needed to represent max_val (at least one bit).
    function automatic int min_cnt_w(input int max_val);
        int w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_gate_sched_timer.sv
// Loadable down-counter used for both the wake settle delay and the idle
// hold-off. Stops at zero; load takes priority over decrement.
module clk_gate_sched_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Counter register: clear, load, or count down toward zero.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_gate_sched.sv
// Clock-gate sequencer: arbitrates clock requests, settles the branch before
// acknowledging, and holds it on for an idle period before gating it off.
module clk_gate_sched
    import clk_gate_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WAKE_CYC = 2,
    parameter int HOLD_CYC = 8,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             FORCE_ON,
    output logic [N_REQ-1:0] ACK,
    output logic             GATE_EN,
    output logic [1:0]       STATE,
    output logic [15:0]      WAKES
);

    localparam int MAX_CYC = (WAKE_CYC > HOLD_CYC) ? WAKE_CYC : HOLD_CYC;

    if ((N_REQ < 1) || (N_REQ > MAX_REQ) || (WAKE_CYC < 1) || (HOLD_CYC < 1) ||
        (CNT_W < min_cnt_w(MAX_CYC - 1))) begin : g_bad_params
        $error("clk_gate_sched: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic [N_REQ-1:0]   r_ack;
    logic               r_gate_en;
    logic [15:0]        r_wakes;
    logic               w_any;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_dec;
    logic               w_zero;

    assign w_any = (|REQ) | FORCE_ON;

    clk_gate_sched_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (CLK),
        .i_clr      (RST),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Next-state and timer control.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            S_OFF: begin
                if (w_any) begin
                    w_next     = S_WAKE;
                    w_load     = 1'b1;
                    w_load_val = WAKE_LOAD;
                end
            end
            S_WAKE: begin
                if (w_zero) begin
                    w_next = S_ON;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_ON: begin
                if (!w_any) begin
                    w_next     = S_HOLD;
                    w_load     = 1'b1;
                    w_load_val = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (w_any) begin
                    w_next = S_ON;
                end else if (w_zero) begin
                    w_next = S_OFF;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next = S_OFF;
        endcase
    end

    // State, gate enable, grants and wake counter; reset stops the branch at once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_OFF;
            r_gate_en <= 1'b0;
            r_ack     <= '0;
            r_wakes   <= '0;
        end else begin
            r_state   <= w_next;
            r_gate_en <= (w_next != S_OFF);
            r_ack     <= (w_next == S_ON) ? REQ : '0;
            if ((r_state == S_OFF) && (w_next == S_WAKE) && (r_wakes != 16'hFFFF)) begin
                r_wakes <= r_wakes + 16'd1;
            end
        end
    end

    assign ACK     = r_ack;
    assign GATE_EN = r_gate_en;
    assign STATE   = r_state;
    assign WAKES   = r_wakes;

endmodule

// File: tb/tb_clk_gate_sched.sv
// Directed bench for clk_gate_sched with WAKE_CYC=2, HOLD_CYC=8, N_REQ=4.
module tb_clk_gate_sched;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic        FORCE_ON;
    logic [3:0]  ACK;
    logic        GATE_EN;
    logic [1:0]  STATE;
    logic [15:0] WAKES;

    int n_checks;
    int n_errors;

    clk_gate_sched #(
        .N_REQ    (4),
        .WAKE_CYC (2),
        .HOLD_CYC (8),
        .CNT_W    (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .FORCE_ON (FORCE_ON),
        .ACK      (ACK),
        .GATE_EN  (GATE_EN),
        .STATE    (STATE),
        .WAKES    (WAKES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  req;
        logic        force_on;
        logic [1:0]  exp_state;
        logic        exp_gate;
        logic [3:0]  exp_ack;
        logic [15:0] exp_wakes;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] st, input logic g,
                             input logic [3:0] a, input logic [15:0] w);
        check({name, ".state"}, {14'd0, STATE}, {14'd0, st});
        check({name, ".gate"},  {15'd0, GATE_EN}, {15'd0, g});
        check({name, ".ack"},   {12'd0, ACK}, {12'd0, a});
        check({name, ".wakes"}, WAKES, w);
    endtask

    // Drive inputs just after a falling edge, then wait for the next falling
    // edge so the following rising edge has been applied.
    task automatic step(input logic rst, input logic [3:0] req, input logic f);
        RST      = rst;
        REQ      = req;
        FORCE_ON = f;
        @(negedge CLK);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST      = 1'b1;
        REQ      = '0;
        FORCE_ON = 1'b0;
        @(negedge CLK);
        step(1'b1, 4'b0000, 1'b0);
        check_all("reset", 2'd0, 1'b0, 4'b0000, 16'd0);

        // Idle after reset.
        for (int i = 0; i < 20; i++) step(1'b0, 4'b0000, 1'b0);
        check_all("idle20", 2'd0, 1'b0, 4'b0000, 16'd0);

        // Wake, ON, hold with re-request, reset from ON.
        tbl.push_back('{"wake1",   1'b0, 4'b0001, 1'b0, 2'd1, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"wake2",   1'b0, 4'b0001, 1'b0, 2'd1, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"on_ack",  1'b0, 4'b0001, 1'b0, 2'd2, 1'b1, 4'b0001, 16'd1});
        tbl.push_back('{"on_add",  1'b0, 4'b0011, 1'b0, 2'd2, 1'b1, 4'b0011, 16'd1});
        tbl.push_back('{"on_swap", 1'b0, 4'b0110, 1'b0, 2'd2, 1'b1, 4'b0110, 16'd1});
        tbl.push_back('{"hold_t7", 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"hold_t6", 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"hold_t5", 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"hold_t4", 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"hold_t3", 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"rewake",  1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 16'd1});
        tbl.push_back('{"on_0011", 1'b0, 4'b0011, 1'b0, 2'd2, 1'b1, 4'b0011, 16'd1});
        tbl.push_back('{"rst_on",  1'b1, 4'b0011, 1'b0, 2'd0, 1'b0, 4'b0000, 16'd0});
        tbl.push_back('{"post_rst",1'b0, 4'b0011, 1'b0, 2'd1, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"drop_wk", 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"on_noreq",1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0000, 16'd1});
        tbl.push_back('{"hold_b",  1'b0, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000, 16'd1});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].force_on);
            check_all(tbl[i].name, tbl[i].exp_state, tbl[i].exp_gate,
                      tbl[i].exp_ack, tbl[i].exp_wakes);
        end

        // Full hold-off: ON, drop REQ, exactly 8 cycles of HOLD, then OFF.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        check_all("on_1000", 2'd2, 1'b1, 4'b1000, 16'd1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b0000, 1'b0);
            check_all($sformatf("hold%0d", k), 2'd3, 1'b1, 4'b0000, 16'd1);
        end
        step(1'b0, 4'b0000, 1'b0);
        check_all("gate_off", 2'd0, 1'b0, 4'b0000, 16'd1);

        // FORCE_ON alone: wakes and reaches ON with no ACK.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        check_all("force_w1", 2'd1, 1'b1, 4'b0000, 16'd1);
        step(1'b0, 4'b0000, 1'b1);
        check_all("force_w2", 2'd1, 1'b1, 4'b0000, 16'd1);
        step(1'b0, 4'b0000, 1'b1);
        check_all("force_on", 2'd2, 1'b1, 4'b0000, 16'd1);
        step(1'b0, 4'b0000, 1'b1);
        check_all("force_on2", 2'd2, 1'b1, 4'b0000, 16'd1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b0000, 1'b0);
            check_all($sformatf("fhold%0d", k), 2'd3, 1'b1, 4'b0000, 16'd1);
        end
        step(1'b0, 4'b0000, 1'b0);
        check_all("force_off", 2'd0, 1'b0, 4'b0000, 16'd1);

        // WAKES saturation: preload near the top, then wake twice.
        force dut.r_wakes = 16'hFFFE;
        @(negedge CLK);
        release dut.r_wakes;
        @(negedge CLK);
        check("sat_preload", WAKES, 16'hFFFE);
        for (int n = 0; n < 2; n++) begin
            step(1'b0, 4'b0000, 1'b1);
            check($sformatf("sat_wake%0d", n), WAKES, 16'hFFFF);
            step(1'b0, 4'b0000, 1'b1);
            step(1'b0, 4'b0000, 1'b1);
            for (int k = 0; k < 9; k++) step(1'b0, 4'b0000, 1'b0);
            check($sformatf("sat_off%0d", n), {14'd0, STATE}, 16'd0);
        end
        check("sat_final", WAKES, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
